gs_capture_stream: RTL and testbench

//  Parametrised multi-channel capture engine between the sample front end and the

---
 rtl/gs_capture_stream_if.sv | 31 +++
 rtl/gs_capture_stream.sv | 160 ++++++++++++++++
 tb/tb_gs_capture_stream.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/gs_capture_stream_if.sv
// Host-side and sample-side signal bundle for gs_capture_stream.
// Signal names follow the Xillybus stream ports they replace.
interface gs_capture_stream_if #(
    parameter int DATA_W = 16,
    parameter int CMD_W  = 32,
    parameter int NCH    = 4
);
    logic                  cmd_wren;
    logic [CMD_W-1:0]      cmd_data;
    logic                  cmd_open;
    logic                  cmd_full;
    logic                  rd_rden;
    logic                  rd_open;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_empty;
    logic                  rd_eof;
    logic                  smp_valid;
    logic [NCH*DATA_W-1:0] smp_data;
    logic                  busy;
    logic                  overflow;

    modport master (
        output cmd_wren, cmd_data, cmd_open, rd_rden, rd_open, smp_valid, smp_data,
        input  cmd_full, rd_data, rd_empty, rd_eof, busy, overflow
    );

    modport slave (
        input  cmd_wren, cmd_data, cmd_open, rd_rden, rd_open, smp_valid, smp_data,
        output cmd_full, rd_data, rd_empty, rd_eof, busy, overflow
    );
endinterface

// File: rtl/gs_capture_stream.sv
// Multi-channel capture engine: a host command arms an N-sample capture, samples are
// serialised channel by channel into a FIFO and read back with an end-of-file marker.
module gs_capture_stream #(
    parameter int DATA_W = 16,
    parameter int CMD_W  = 32,
    parameter int NCH    = 4,
    parameter int DEPTH  = 1024
) (
    input logic           bus_clk,
    input logic           srst,
    gs_capture_stream_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_rd_open_q;
    logic [AW:0]           r_wptr;
    logic [AW:0]           r_rptr;
    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DATA_W-1:0]     r_rd_data;
    logic [NCH*DATA_W-1:0] r_hold;
    logic [NCH-1:0]        r_pend;
    logic [NCH-1:0]        r_mask;
    logic [15:0]           r_cnt;
    logic [15:0]           r_n;
    logic                  r_overflow;

    logic                  w_close;
    logic                  w_abort;
    logic                  w_flush;
    logic                  w_start;
    logic [15:0]           w_cmd_n;
    logic [NCH-1:0]        w_cmd_mask;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd_ok;
    logic                  w_wr;
    logic                  w_wr_ok;
    logic [NCH-1:0]        w_onehot;
    logic [NCH-1:0]        w_rest;
    logic                  w_last;
    logic                  w_cap_end;
    logic                  w_accept;
    logic                  w_overrun;
    logic [DATA_W-1:0]     w_wr_word;
    logic                  w_unused;

    assign w_close    = r_rd_open_q & ~bus.rd_open;
    assign w_abort    = bus.cmd_wren & bus.cmd_data[30];
    assign w_flush    = w_abort | w_close;
    assign w_cmd_n    = bus.cmd_data[15:0];
    assign w_cmd_mask = bus.cmd_data[16 +: NCH];
    assign w_start    = (r_state == S_IDLE) & bus.cmd_wren & bus.cmd_data[31]
                        & ~bus.cmd_data[30] & bus.rd_open;
    assign w_unused   = ^{bus.cmd_open, bus.cmd_data};

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_rd_ok = bus.rd_rden & ~w_empty;
    assign w_wr    = |r_pend;
    assign w_wr_ok = w_wr & ~w_full;

    // Lowest pending channel is written this cycle; w_rest is what remains after it.
    assign w_onehot  = r_pend & (~r_pend + NCH'(1));
    assign w_rest    = r_pend & ~w_onehot;
    assign w_last    = w_wr & (w_rest == '0);
    assign w_cap_end = w_last & (r_cnt == r_n - 16'd1);
    assign w_accept  = (r_state == S_CAPTURE) & bus.smp_valid & ~w_cap_end;
    assign w_overrun = w_accept & (w_rest != '0);

    always_comb begin
        w_wr_word = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (w_onehot[c]) w_wr_word = r_hold[c*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge bus_clk) begin
        if (srst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_start)
                               w_state_nxt = (w_cmd_n == '0 || w_cmd_mask == '0) ? S_DONE : S_CAPTURE;
                S_CAPTURE: if (w_cap_end) w_state_nxt = S_DRAIN;
                S_DRAIN:   if (w_empty)   w_state_nxt = S_DONE;
                S_DONE:    w_state_nxt = S_DONE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.cmd_full = 1'b0;
        bus.busy     = (r_state != S_IDLE);
        bus.rd_eof   = (r_state == S_DONE) & w_empty;
        bus.rd_empty = w_empty;
        bus.rd_data  = r_rd_data;
        bus.overflow = r_overflow;
    end

    always_ff @(posedge bus_clk) begin
        if (srst) begin
            r_rd_open_q <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_rd_data   <= '0;
            r_hold      <= '0;
            r_pend      <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_n         <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_rd_open_q <= bus.rd_open;
            if (w_flush) begin
                r_wptr    <= '0;
                r_rptr    <= '0;
                r_rd_data <= '0;
                r_pend    <= '0;
                r_cnt     <= '0;
            end else begin
                if (w_start) begin
                    r_n        <= w_cmd_n;
                    r_mask     <= w_cmd_mask;
                    r_cnt      <= '0;
                    r_overflow <= 1'b0;
                end
                if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
                if (w_rd_ok) begin
                    r_rptr    <= r_rptr + 1'b1;
                    r_rd_data <= r_mem[r_rptr[AW-1:0]];
                end
                if (w_last) r_cnt <= r_cnt + 16'd1;
                // A new strobe replaces whatever the old sample still had pending.
                if (w_accept) begin
                    r_hold <= bus.smp_data;
                    r_pend <= r_mask;
                end else if (w_wr) begin
                    r_pend <= w_rest;
                end
                if (w_overrun | (w_wr & w_full)) r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge bus_clk) begin
        if (!srst && !w_flush && w_wr_ok) r_mem[r_wptr[AW-1:0]] <= w_wr_word;
    end
endmodule

// File: tb/tb_gs_capture_stream.sv
// Directed bench for gs_capture_stream (NCH=4, DEPTH=16): basic capture, zero count,
// FIFO overflow, strobe overrun, abort, close and mid-capture reset.
module tb_gs_capture_stream;
    logic bus_clk = 1'b0;
    logic srst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 bus_clk = ~bus_clk;

    gs_capture_stream_if #(.DATA_W(16), .CMD_W(32), .NCH(4)) bus ();

    gs_capture_stream #(.DATA_W(16), .CMD_W(32), .NCH(4), .DEPTH(16)) dut (
        .bus_clk (bus_clk),
        .srst    (srst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge bus_clk);
    endtask

    task automatic send_cmd(input logic [31:0] w);
        bus.cmd_wren = 1'b1;
        bus.cmd_data = w;
        @(negedge bus_clk);
        bus.cmd_wren = 1'b0;
        bus.cmd_data = '0;
    endtask

    task automatic strobe(input logic [15:0] d0, d1, d2, d3);
        bus.smp_valid = 1'b1;
        bus.smp_data  = {d3, d2, d1, d0};
        @(negedge bus_clk);
        bus.smp_valid = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [15:0] exp);
        int t = 0;
        while (bus.rd_empty && t < 50) begin
            @(negedge bus_clk);
            t++;
        end
        if (bus.rd_empty) begin
            check($sformatf("%s_timeout", tag), bus.rd_empty, 0);
        end else begin
            bus.rd_rden = 1'b1;
            @(negedge bus_clk);
            bus.rd_rden = 1'b0;
            check(tag, bus.rd_data, exp);
        end
    endtask

    task automatic close_file();
        bus.rd_open = 1'b0;
        @(negedge bus_clk);
        bus.rd_open = 1'b1;
        @(negedge bus_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        srst          = 1'b1;
        bus.cmd_wren  = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_open  = 1'b1;
        bus.rd_rden   = 1'b0;
        bus.rd_open   = 1'b1;
        bus.smp_valid = 1'b0;
        bus.smp_data  = '0;
        tick(3);
        check("rst_busy", bus.busy, 0);
        check("rst_empty", bus.rd_empty, 1);
        check("rst_eof", bus.rd_eof, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_data", bus.rd_data, 0);
        check("rst_full", bus.cmd_full, 0);
        srst = 1'b0;
        tick(1);

        // start while the read file is closed must be ignored
        bus.rd_open = 1'b0;
        tick(1);
        send_cmd(32'h8005_0003);
        check("closed_start_ignored", bus.busy, 0);
        bus.rd_open = 1'b1;
        tick(2);

        // 1: basic, N=3 mask=0101
        send_cmd(32'h8005_0003);
        check("t1_busy", bus.busy, 1);
        for (int i = 0; i < 3; i++) begin
            strobe(16'h1000 + 16'(i), 16'hAAAA, 16'h3000 + 16'(i), 16'hBBBB);
            if (i == 0) begin
                check("t1_lat_empty_hi", bus.rd_empty, 1);
                tick(1);
                check("t1_lat_empty_lo", bus.rd_empty, 0);
                tick(6);
            end else begin
                tick(7);
            end
        end
        for (int i = 0; i < 3; i++) begin
            read_word($sformatf("t1_rd%0d_ch0", i), 16'h1000 + 16'(i));
            read_word($sformatf("t1_rd%0d_ch2", i), 16'h3000 + 16'(i));
        end
        tick(3);
        check("t1_eof", bus.rd_eof, 1);
        check("t1_busy_done", bus.busy, 1);
        bus.rd_open = 1'b0;
        tick(1);
        check("t6_close_eof", bus.rd_eof, 0);
        check("t6_close_idle", bus.busy, 0);
        bus.rd_open = 1'b1;
        tick(1);

        // 2: zero count
        send_cmd(32'h800F_0000);
        check("t2_busy", bus.busy, 1);
        check("t2_eof", bus.rd_eof, 1);
        check("t2_empty", bus.rd_empty, 1);
        tick(3);
        check("t2_nowords", bus.rd_empty, 1);
        close_file();

        // 3: overflow with no reads, N=10 mask=F into a 16-word FIFO
        send_cmd(32'h800F_000A);
        for (int i = 0; i < 10; i++) begin
            strobe(16'(i), 16'h0100 + 16'(i), 16'h0200 + 16'(i), 16'h0300 + 16'(i));
            tick(5);
        end
        tick(4);
        check("t3_ovf", bus.overflow, 1);
        check("t3_eof_pending", bus.rd_eof, 0);
        check("t3_busy", bus.busy, 1);
        for (int k = 0; k < 16; k++)
            read_word($sformatf("t3_rd%0d", k), 16'((k % 4) * 16'h0100 + k / 4));
        tick(3);
        check("t3_eof", bus.rd_eof, 1);
        check("t3_empty", bus.rd_empty, 1);
        close_file();
        check("t3_ovf_kept", bus.overflow, 1);

        // 4: strobe overrun, N=1 mask=F
        send_cmd(32'h800F_0001);
        check("t4_ovf_cleared", bus.overflow, 0);
        bus.smp_valid = 1'b1;
        bus.smp_data  = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        @(negedge bus_clk);
        bus.smp_data  = {16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0};
        @(negedge bus_clk);
        bus.smp_valid = 1'b0;
        tick(8);
        check("t4_ovf", bus.overflow, 1);
        read_word("t4_a0", 16'h00A0);
        read_word("t4_b0", 16'h00B0);
        read_word("t4_b1", 16'h00B1);
        read_word("t4_b2", 16'h00B2);
        read_word("t4_b3", 16'h00B3);
        tick(3);
        check("t4_eof", bus.rd_eof, 1);
        close_file();

        // 5: abort mid-capture, then a fresh run
        send_cmd(32'h800F_0064);
        for (int i = 0; i < 5; i++) begin
            strobe(16'h5000 + 16'(i), 16'h5100, 16'h5200, 16'h5300);
            tick(5);
        end
        send_cmd(32'h4000_0000);
        check("t5_abort_busy", bus.busy, 0);
        check("t5_abort_empty", bus.rd_empty, 1);
        send_cmd(32'h8002_0002);
        check("t5_restart_busy", bus.busy, 1);
        strobe(16'h6000, 16'h6100, 16'h6200, 16'h6300);
        tick(5);
        strobe(16'h6001, 16'h6101, 16'h6201, 16'h6301);
        tick(5);
        read_word("t5_rd0", 16'h6100);
        read_word("t5_rd1", 16'h6101);
        tick(3);
        check("t5_eof", bus.rd_eof, 1);
        close_file();

        // 6: reset in the middle of a capture
        send_cmd(32'h800F_0032);
        bus.smp_valid = 1'b1;
        bus.smp_data  = {16'h7003, 16'h7002, 16'h7001, 16'h7000};
        @(negedge bus_clk);
        bus.smp_data  = {16'h7013, 16'h7012, 16'h7011, 16'h7010};
        @(negedge bus_clk);
        bus.smp_valid = 1'b0;
        tick(2);
        check("t6_pre_ovf", bus.overflow, 1);
        read_word("t6_pre_rd", 16'h7000);
        srst = 1'b1;
        tick(1);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_empty", bus.rd_empty, 1);
        check("t6_rst_eof", bus.rd_eof, 0);
        check("t6_rst_ovf", bus.overflow, 0);
        check("t6_rst_data", bus.rd_data, 0);
        srst = 1'b0;
        tick(2);
        check("t6_post_busy", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
